// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate prescaler, h/v position counters,
// registered sync/visible decode, line/frame start pulses and a frame counter.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int CW       = 10,
    parameter int FCW      = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    output logic           pxl_tick,
    output logic           hsync,
    output logic           vsync,
    output logic [CW-1:0]  hpos,
    output logic [CW-1:0]  vpos,
    output logic           pxl_en,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (H_TOTAL >= 2 ** CW) begin : g_bad_h
        $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL >= 2 ** CW) begin : g_bad_v
        $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end

    logic [DW-1:0] div_cnt;
    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;
    logic          line_q;
    logic          frame_q;

    assign pxl_tick = en && (div_cnt == DIV_MAX);

    // Decode is computed from the next position so the registered outputs
    // always describe the hpos/vpos they are presented alongside.
    always_comb begin
        h_next = hpos;
        v_next = vpos;
        if (pxl_tick) begin
            if (hpos == H_LAST) begin
                h_next = '0;
                v_next = (vpos == V_LAST) ? '0 : vpos + CW'(1);
            end else begin
                h_next = hpos + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt   <= '0;
            hpos      <= H_LAST;
            vpos      <= V_LAST;
            pxl_en    <= 1'b0;
            hsync     <= ~HS_POL;
            vsync     <= ~VS_POL;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
            frame_cnt <= '0;
        end else if (en) begin
            div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + DW'(1);
            hpos    <= h_next;
            vpos    <= v_next;
            pxl_en  <= (h_next < H_VIS) && (v_next < V_VIS);
            hsync   <= ((h_next >= HS_START) && (h_next < HS_END)) ? HS_POL : ~HS_POL;
            vsync   <= ((v_next >= VS_START) && (v_next < VS_END)) ? VS_POL : ~VS_POL;
            line_q  <= pxl_tick && (h_next == '0);
            frame_q <= pxl_tick && (h_next == '0) && (v_next == '0);
            if (pxl_tick && (h_next == '0) && (v_next == '0)) begin
                frame_cnt <= frame_cnt + FCW'(1);
            end
        end else begin
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end
    end

    // Pulses are suppressed while frozen so they never straddle a pause.
    assign line_start  = line_q && en;
    assign frame_start = frame_q && en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default geometry for line-level checks,
// short-frame variants for frame-level and fast-clock/polarity checks.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Instance A: all defaults
    logic        a_rst, a_en, a_tick, a_hs, a_vs, a_pe, a_ls, a_fs;
    logic [9:0]  a_hpos, a_vpos;
    logic [15:0] a_fc;
    // Instance B: default horizontal, 8-line frame
    logic        b_rst, b_en, b_tick, b_hs, b_vs, b_pe, b_ls, b_fs;
    logic [9:0]  b_hpos, b_vpos;
    logic [15:0] b_fc;
    // Instance C: HS_POL=1, CLK_DIV=1, FCW=2, 7-line frame
    logic        c_rst, c_en, c_tick, c_hs, c_vs, c_pe, c_ls, c_fs;
    logic [9:0]  c_hpos, c_vpos;
    logic [1:0]  c_fc;

    vga_timing_gen dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .pxl_tick(a_tick), .hsync(a_hs), .vsync(a_vs),
        .hpos(a_hpos), .vpos(a_vpos), .pxl_en(a_pe), .line_start(a_ls),
        .frame_start(a_fs), .frame_cnt(a_fc)
    );

    vga_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .pxl_tick(b_tick), .hsync(b_hs), .vsync(b_vs),
        .hpos(b_hpos), .vpos(b_vpos), .pxl_en(b_pe), .line_start(b_ls),
        .frame_start(b_fs), .frame_cnt(b_fc)
    );

    vga_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                     .HS_POL(1'b1), .CLK_DIV(1), .FCW(2)) dut_c (
        .clk(clk), .rst(c_rst), .en(c_en), .pxl_tick(c_tick), .hsync(c_hs), .vsync(c_vs),
        .hpos(c_hpos), .vpos(c_vpos), .pxl_en(c_pe), .line_start(c_ls),
        .frame_start(c_fs), .frame_cnt(c_fc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; a_en = 1'b1;
        step(); step();
        checks++; if (a_hpos !== 10'd799) begin failures++; $display("FAIL reset_hpos got=%0d exp=799", a_hpos); end
        checks++; if (a_vpos !== 10'd524) begin failures++; $display("FAIL reset_vpos got=%0d exp=524", a_vpos); end
        checks++; if (a_pe !== 1'b0) begin failures++; $display("FAIL reset_pxl_en got=%b exp=0", a_pe); end
        checks++; if (a_hs !== 1'b1 || a_vs !== 1'b1) begin failures++; $display("FAIL reset_sync got=%b%b exp=11", a_hs, a_vs); end
        checks++; if (a_fc !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", a_fc); end
        checks++; if (a_ls !== 1'b0 || a_fs !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", a_ls, a_fs); end
        checks++; if (a_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", a_tick); end
    endtask

    task automatic test_release();
        a_rst = 1'b0;
        step();
        checks++; if (a_tick !== 1'b1) begin failures++; $display("FAIL release_tick1 got=%b exp=1", a_tick); end
        checks++; if (a_hpos !== 10'd799) begin failures++; $display("FAIL release_hold got=%0d exp=799", a_hpos); end
        step();
        checks++; if (a_hpos !== 10'd0 || a_vpos !== 10'd0) begin failures++; $display("FAIL release_pos got=%0d,%0d exp=0,0", a_hpos, a_vpos); end
        checks++; if (a_pe !== 1'b1) begin failures++; $display("FAIL release_pxl_en got=%b exp=1", a_pe); end
        checks++; if (a_fs !== 1'b1 || a_ls !== 1'b1) begin failures++; $display("FAIL release_pulses got=%b%b exp=11", a_fs, a_ls); end
        checks++; if (a_fc !== 16'd1) begin failures++; $display("FAIL release_frame_cnt got=%0d exp=1", a_fc); end
        checks++; if (a_tick !== 1'b0) begin failures++; $display("FAIL release_tick2 got=%b exp=0", a_tick); end
    endtask

    task automatic test_line();
        int hs_low = 0, hs_min = 1023, hs_max = 0, pe_cnt = 0, ls_cnt = 0;
        for (int i = 0; i < 1600; i++) begin
            if (a_hs === 1'b0) begin
                hs_low++;
                if (int'(a_hpos) < hs_min) hs_min = int'(a_hpos);
                if (int'(a_hpos) > hs_max) hs_max = int'(a_hpos);
            end
            if (a_pe === 1'b1) pe_cnt++;
            if (a_ls === 1'b1) ls_cnt++;
            step();
        end
        checks++; if (hs_low != 192) begin failures++; $display("FAIL line_hsync_len got=%0d exp=192", hs_low); end
        checks++; if (hs_min != 656 || hs_max != 751) begin failures++; $display("FAIL line_hsync_range got=%0d..%0d exp=656..751", hs_min, hs_max); end
        checks++; if (pe_cnt != 1280) begin failures++; $display("FAIL line_pxl_en_len got=%0d exp=1280", pe_cnt); end
        checks++; if (ls_cnt != 1) begin failures++; $display("FAIL line_start_count got=%0d exp=1", ls_cnt); end
        checks++; if (a_ls !== 1'b1 || a_fs !== 1'b0) begin failures++; $display("FAIL line_period_pulse got=%b%b exp=10", a_ls, a_fs); end
        checks++; if (a_hpos !== 10'd0 || a_vpos !== 10'd1) begin failures++; $display("FAIL line_next_pos got=%0d,%0d exp=0,1", a_hpos, a_vpos); end
    endtask

    task automatic test_enable();
        int n = 0, bad = 0;
        while (a_hpos !== 10'd300 && n < 2000) begin step(); n++; end
        checks++; if (a_hpos !== 10'd300) begin failures++; $display("FAIL enable_reach got=%0d exp=300", a_hpos); end
        a_en = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (a_tick !== 1'b0 || a_hpos !== 10'd300 || a_ls !== 1'b0 || a_pe !== 1'b1) bad++;
            step();
        end
        checks++; if (bad != 0 || a_hpos !== 10'd300) begin failures++; $display("FAIL enable_freeze got=%0d bad cycles hpos=%0d exp=0 bad hpos=300", bad, a_hpos); end
        a_en = 1'b1;
        step();
        checks++; if (a_hpos !== 10'd300 || a_tick !== 1'b1) begin failures++; $display("FAIL enable_resume1 got=%0d tick=%b exp=300 tick=1", a_hpos, a_tick); end
        step();
        checks++; if (a_hpos !== 10'd301) begin failures++; $display("FAIL enable_resume2 got=%0d exp=301", a_hpos); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (a_hpos !== 10'd400 && n < 2000) begin step(); n++; end
        checks++; if (a_hpos !== 10'd400 || a_pe !== 1'b1) begin failures++; $display("FAIL midrst_reach got=%0d pe=%b exp=400 pe=1", a_hpos, a_pe); end
        a_rst = 1'b1;
        step();
        checks++; if (a_hpos !== 10'd799 || a_vpos !== 10'd524) begin failures++; $display("FAIL midrst_pos got=%0d,%0d exp=799,524", a_hpos, a_vpos); end
        checks++; if (a_pe !== 1'b0 || a_hs !== 1'b1 || a_vs !== 1'b1) begin failures++; $display("FAIL midrst_decode got=%b%b%b exp=011", a_pe, a_hs, a_vs); end
        checks++; if (a_fc !== 16'd0) begin failures++; $display("FAIL midrst_frame_cnt got=%0d exp=0", a_fc); end
    endtask

    task automatic test_frames();
        int cyc = 0, fs_n = 0, vs_low = 0, vs_min = 1023, vs_max = 0, ls_n = 0, glitch = 0;
        int fs_t[2];
        int fc_at[2];
        logic prev_vs;
        logic [9:0] prev_vpos;
        fs_t[0] = 0; fs_t[1] = 0; fc_at[0] = 0; fc_at[1] = 0;
        b_rst = 1'b1; b_en = 1'b1;
        step();
        b_rst = 1'b0;
        prev_vs = b_vs; prev_vpos = b_vpos;
        while (cyc < 30000) begin
            if (b_fs === 1'b1) begin
                if (fs_n < 2) begin fs_t[fs_n] = cyc; fc_at[fs_n] = int'(b_fc); end
                fs_n++;
            end
            if (fs_n >= 2) break;
            if (b_vs !== prev_vs && b_vpos === prev_vpos) glitch++;
            if (fs_n == 1) begin
                if (b_vs === 1'b0) begin
                    vs_low++;
                    if (int'(b_vpos) < vs_min) vs_min = int'(b_vpos);
                    if (int'(b_vpos) > vs_max) vs_max = int'(b_vpos);
                end
                if (b_ls === 1'b1) ls_n++;
            end
            prev_vs = b_vs; prev_vpos = b_vpos;
            step();
            cyc++;
        end
        checks++; if (fs_n != 2) begin failures++; $display("FAIL frames_seen got=%0d exp=2", fs_n); end
        checks++; if (fs_t[0] != 2) begin failures++; $display("FAIL frames_first_at got=%0d exp=2", fs_t[0]); end
        checks++; if (fs_t[1] - fs_t[0] != 12800) begin failures++; $display("FAIL frames_period got=%0d exp=12800", fs_t[1] - fs_t[0]); end
        checks++; if (fc_at[0] != 1 || fc_at[1] != 2) begin failures++; $display("FAIL frames_cnt got=%0d,%0d exp=1,2", fc_at[0], fc_at[1]); end
        checks++; if (vs_low != 3200) begin failures++; $display("FAIL frames_vsync_len got=%0d exp=3200", vs_low); end
        checks++; if (vs_min != 5 || vs_max != 6) begin failures++; $display("FAIL frames_vsync_range got=%0d..%0d exp=5..6", vs_min, vs_max); end
        checks++; if (ls_n != 8) begin failures++; $display("FAIL frames_lines got=%0d exp=8", ls_n); end
        checks++; if (glitch != 0) begin failures++; $display("FAIL frames_vsync_stable got=%0d exp=0", glitch); end
        b_rst = 1'b1;
    endtask

    task automatic test_fast();
        int cyc = 0, fs_n = 0, tick_low = 0, hs_high = 0, line_cyc = 0;
        int fc_at[4];
        for (int i = 0; i < 4; i++) fc_at[i] = -1;
        c_rst = 1'b1; c_en = 1'b1;
        step();
        c_rst = 1'b0;
        checks++; if (c_hs !== 1'b0) begin failures++; $display("FAIL fast_reset_hsync got=%b exp=0", c_hs); end
        while (cyc < 20000) begin
            if (c_tick !== 1'b1) tick_low++;
            if (c_fs === 1'b1) begin
                if (fs_n < 4) fc_at[fs_n] = int'(c_fc);
                fs_n++;
            end
            if (fs_n >= 4) break;
            if (fs_n >= 1 && line_cyc < 800) begin
                if (c_hs === 1'b1) hs_high++;
                line_cyc++;
            end
            step();
            cyc++;
        end
        checks++; if (fs_n != 4) begin failures++; $display("FAIL fast_frames_seen got=%0d exp=4", fs_n); end
        checks++; if (tick_low != 0) begin failures++; $display("FAIL fast_tick got=%0d low cycles exp=0", tick_low); end
        checks++; if (hs_high != 96) begin failures++; $display("FAIL fast_hsync_len got=%0d exp=96", hs_high); end
        checks++; if (fc_at[0] != 1 || fc_at[1] != 2 || fc_at[2] != 3 || fc_at[3] != 0)
            begin failures++; $display("FAIL fast_frame_cnt got=%0d,%0d,%0d,%0d exp=1,2,3,0", fc_at[0], fc_at[1], fc_at[2], fc_at[3]); end
        c_rst = 1'b1;
    endtask

    initial begin
        a_rst = 1'b1; a_en = 1'b0;
        b_rst = 1'b1; b_en = 1'b0;
        c_rst = 1'b1; c_en = 1'b0;
        test_reset();
        test_release();
        test_line();
        test_enable();
        test_reset_mid();
        test_frames();
        test_fast();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have one clock (clk); reset (rst) is synchronous and active-high.
REQ-002 Parameters SHALL be, one per line (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, pixels
- H_SYNC, 96, hsync width, pixels
- H_BP, 48, horizontal back porch, pixels
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vsync width, lines
- V_BP, 33, vertical back porch, lines
- HS_POL, 0, asserted hsync level
- VS_POL, 0, asserted vsync level
- CLK_DIV, 2, clk cycles per pixel (>=1)
- CW, 10, hpos/vpos width
- FCW, 16, frame counter width
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  system clock
- rst  in  1  sync active-high reset
- en  in  1  run enable; low freezes all timing
- pxl_tick  out  1  pixel clock enable
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- hpos  out  CW  horizontal counter
- vpos  out  CW  vertical counter
- pxl_en  out  1  visible-region flag
- line_start  out  1  one-clk pulse, new line
- frame_start  out  1  one-clk pulse, new frame
- frame_cnt  out  FCW  frames started since reset

Function
REQ-004 H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP SHALL be < 2^CW; violations, or CLK_DIV<1, SHALL stop elaboration.
REQ-005 Prescaler div_cnt SHALL count 0..CLK_DIV-1 on each clk edge with en=1 and wrap to 0; pxl_tick SHALL equal en AND (div_cnt==CLK_DIV-1), so with CLK_DIV=1 pxl_tick=en.
REQ-006 On each edge with pxl_tick=1, hpos SHALL increment and wrap from H_TOTAL-1 to 0; on that wrap vpos SHALL increment and wrap from V_TOTAL-1 to 0.
REQ-007 pxl_en, hsync and vsync SHALL be registered and updated on the same edge as hpos/vpos, so in every cycle they decode the current hpos/vpos.
REQ-008 pxl_en SHALL be 1 iff hpos<H_ACTIVE and vpos<V_ACTIVE.
REQ-009 hsync SHALL equal HS_POL iff H_ACTIVE+H_FP <= hpos < H_ACTIVE+H_FP+H_SYNC, and ~HS_POL otherwise.
REQ-010 vsync SHALL equal VS_POL iff V_ACTIVE+V_FP <= vpos < V_ACTIVE+V_FP+V_SYNC, and ~VS_POL otherwise; it changes only with vpos.
REQ-011 line_start SHALL be high for exactly the one clk cycle following the edge at which hpos becomes 0.
REQ-012 frame_start SHALL be high for exactly the one clk cycle following the edge at which (hpos,vpos) becomes (0,0); line_start SHALL also be high in that cycle.
REQ-013 frame_cnt SHALL increment on the edge at which frame_start is set, and wrap modulo 2^FCW.
REQ-014 While en=0, div_cnt, hpos, vpos, frame_cnt and all decoded outputs SHALL hold; pxl_tick, line_start and frame_start SHALL be 0.
REQ-015 rst SHALL take priority over en.

Reset
REQ-016 On an edge with rst=1, the following SHALL be loaded regardless of the current state:
- div_cnt=0
- hpos=H_TOTAL-1, vpos=V_TOTAL-1 (last blanking pixel)
- pxl_en=0, hsync=~HS_POL, vsync=~VS_POL
- line_start=0, frame_start=0, frame_cnt=0
REQ-017 This load SHALL make the first pxl_tick after reset move the counters to (0,0) and produce frame_start with frame_cnt=1.

Verification
REQ-018 The bench SHALL cover the following directed scenarios (defaults unless stated; H_TOTAL=800, V_TOTAL=525):
- Release rst with en=1 -> pxl_tick at the 2nd clk edge; next cycle hpos=0, vpos=0, pxl_en=1, frame_start=1, line_start=1, frame_cnt=1.
- Free run one line -> hsync=0 exactly for hpos 656..751 (192 clk); line_start period 1600 clk; pxl_en=1 for 1280 clk per active line.
- Free run two frames -> vsync=0 for vpos 490..491 only (3200 clk); frame_start period 840000 clk; frame_cnt 1 -> 2.
- Drop en for 100 clk at hpos=300 -> hpos stays 300, pxl_tick=0 throughout; after en returns, hpos=301 after 2 clk.
- Assert rst at (400,200), mid-frame -> next cycle hpos=799, vpos=524, pxl_en=0, hsync=1, vsync=1, frame_cnt=0.
- HS_POL=1, CLK_DIV=1, FCW=2 -> pxl_tick=1 every cycle; hsync=1 for 96 clk per line; frame_cnt sequence 1,2,3,0 over four frame_starts.
